mux_rr_arbiter: RTL and testbench

Parametrised N-channel, W-bit multiplexer with per-channel valid/ready handshakes and a registered output stage. Two modes: manual mode forwards the channel named by `selection`; round-robin mode arbitrates fairly among valid channels. The output is held stable under backpressure. Used wherever several datapath sources share one CPU-internal bus or consumer.

---
 rtl/mux_rr_arbiter.sv | 92 +++++++++
 tb/tb_mux_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// N-channel valid/ready multiplexer with a registered output stage.
// Channels are picked by index in manual mode, or by rotating priority in round-robin mode.
module mux_rr_arbiter #(
  parameter int unsigned  DATA_WIDTH   = 8,
  parameter int unsigned  NUM_CHANNELS = 4,
  localparam int unsigned SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] inputData,
  input  logic [NUM_CHANNELS-1:0]            inputValid,
  output logic [NUM_CHANNELS-1:0]            inputReady,
  input  logic                               mode,
  input  logic [SEL_WIDTH-1:0]               selection,
  output logic [DATA_WIDTH-1:0]              outputData,
  output logic                               outputValid,
  input  logic                               outputReady,
  output logic [SEL_WIDTH-1:0]               outputChannel
);

  logic [SEL_WIDTH-1:0]  last_grant;
  logic [SEL_WIDTH-1:0]  grant;
  logic                  grant_valid;
  logic                  load_en;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] grant_data;

  assign load_en  = !outputValid || outputReady;
  assign transfer = load_en && grant_valid;

  // Grant selection. Round-robin takes the lowest valid index above last_grant,
  // otherwise wraps to the lowest valid index overall; downward loops let the
  // lowest index win. Indices >= NUM_CHANNELS never exist, so wrap needs no skip.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (mode) begin
      for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
        if (inputValid[i] && (i > int'(last_grant))) begin
          grant       = SEL_WIDTH'(i);
          grant_valid = 1'b1;
        end
      end
      if (!grant_valid) begin
        for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
          if (inputValid[i]) begin
            grant       = SEL_WIDTH'(i);
            grant_valid = 1'b1;
          end
        end
      end
    end else begin
      // Out-of-range selections match no channel and so never grant.
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        if ((selection == SEL_WIDTH'(i)) && inputValid[i]) begin
          grant       = SEL_WIDTH'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Per-channel ready and the granted channel's data word.
  always_comb begin
    inputReady = '0;
    grant_data = '0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        inputReady[i] = load_en && grant_valid;
        grant_data    = inputData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register: load on transfer, clear valid on drain without reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outputData    <= '0;
      outputValid   <= 1'b0;
      outputChannel <= '0;
      last_grant    <= SEL_WIDTH'(NUM_CHANNELS - 1);
    end else if (transfer) begin
      outputData    <= grant_data;
      outputValid   <= 1'b1;
      outputChannel <= grant;
      last_grant    <= grant;
    end else if (outputReady) begin
      outputValid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: a 4x8 and a 3x16 instance run in lockstep against
// a queue-free arithmetic reference model, with directed and random steps.
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [15:0] din  [2][4];
  logic [3:0]  vld  [2];
  logic        md   [2];
  int          sel  [2];
  logic        ordy [2];

  logic [31:0] in_data4;
  logic [3:0]  ready4;
  logic [7:0]  od4;
  logic        ov4;
  logic [1:0]  oc4;

  logic [47:0] in_data3;
  logic [2:0]  ready3;
  logic [15:0] od3;
  logic        ov3;
  logic [1:0]  oc3;

  assign in_data4 = {din[0][3][7:0], din[0][2][7:0], din[0][1][7:0], din[0][0][7:0]};
  assign in_data3 = {din[1][2], din[1][1], din[1][0]};

  mux_rr_arbiter #(.DATA_WIDTH(8), .NUM_CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .inputData(in_data4), .inputValid(vld[0]),
    .inputReady(ready4), .mode(md[0]), .selection(2'(sel[0])),
    .outputData(od4), .outputValid(ov4), .outputReady(ordy[0]),
    .outputChannel(oc4));

  mux_rr_arbiter #(.DATA_WIDTH(16), .NUM_CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .inputData(in_data3), .inputValid(vld[1][2:0]),
    .inputReady(ready3), .mode(md[1]), .selection(2'(sel[1])),
    .outputData(od3), .outputValid(ov3), .outputReady(ordy[1]),
    .outputChannel(oc3));

  // Reference model state per instance
  int          n     [2] = '{4, 3};
  int          m_last[2];
  logic        m_valid[2];
  logic [15:0] m_data[2];
  int          m_chan[2];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d]  = n[d] - 1;
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_chan[d]  = 0;
    end
  endtask

  // Which channel the spec's rules grant this cycle, or -1 for none.
  function automatic int model_grant(input int d);
    if (m_valid[d] && !ordy[d]) return -1;
    if (!md[d]) begin
      if (sel[d] < n[d] && vld[d][sel[d]]) return sel[d];
      return -1;
    end
    for (int k = 1; k <= n[d]; k++) begin
      int c;
      c = (m_last[d] + k) % n[d];
      if (vld[d][c]) return c;
    end
    return -1;
  endfunction

  // One clock: check readies before the edge, advance the model, check outputs after.
  task automatic step();
    int g[2];
    logic [31:0] exp_rdy;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d]    = model_grant(d);
      exp_rdy = (g[d] >= 0) ? (32'd1 << g[d]) : 32'd0;
      check(d == 0 ? "ready4" : "ready3", d == 0 ? 32'(ready4) : 32'(ready3), exp_rdy);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (g[d] >= 0) begin
        m_valid[d] = 1'b1;
        m_data[d]  = (d == 0) ? (din[0][g[d]] & 16'h00ff) : din[1][g[d]];
        m_chan[d]  = g[d];
        m_last[d]  = g[d];
      end else if (m_valid[d] && ordy[d]) begin
        m_valid[d] = 1'b0;
      end
    end
    #1;
    check("valid4", 32'(ov4), 32'(m_valid[0]));
    check("data4",  32'(od4), 32'(m_data[0]));
    check("chan4",  32'(oc4), 32'(m_chan[0]));
    check("valid3", 32'(ov3), 32'(m_valid[1]));
    check("data3",  32'(od3), 32'(m_data[1]));
    check("chan3",  32'(oc3), 32'(m_chan[1]));
    @(negedge clk);
  endtask

  task automatic randomize_data();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) din[d][c] = 16'($urandom);
  endtask

  logic [7:0]  held_d;
  logic [1:0]  held_c;

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 4'hf; md[d] = 1'b1; sel[d] = 0; ordy[d] = 1'b1;
    end
    randomize_data();
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid4", 32'(ov4), 32'd0);
    check("rst_data4",  32'(od4), 32'd0);
    check("rst_chan4",  32'(oc4), 32'd0);
    check("rst_valid3", 32'(ov3), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with everything valid rotates through all channels.
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      step();
      check("rr_seq4", 32'(oc4), 32'(i % 4));
      check("rr_seq3", 32'(oc3), 32'(i % 3));
      check("rr_keep_valid", 32'(ov4), 32'd1);
    end

    // Manual mode; the 3-channel instance gets an out-of-range selection.
    md[0] = 1'b0; sel[0] = 2; vld[0] = 4'b0100; din[0][2] = 16'h00a5;
    md[1] = 1'b0; sel[1] = 3;
    #1 check("man_ready4", 32'(ready4), 32'h4);
    check("man_oob_ready3", 32'(ready3), 32'h0);
    step();
    check("man_data4", 32'(od4), 32'ha5);
    check("man_chan4", 32'(oc4), 32'd2);
    sel[0] = 3;
    step();
    check("man_nogrant4", 32'(ov4), 32'd0);
    md[1] = 1'b1; sel[1] = 0;

    // Backpressure freezes the output register, then drain and reload together.
    md[0] = 1'b1; vld[0] = 4'hf;
    step();
    held_d = od4; held_c = oc4;
    ordy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      step();
      check("bp_data", 32'(od4), 32'(held_d));
      check("bp_chan", 32'(oc4), 32'(held_c));
    end
    ordy[0] = 1'b1;
    step();
    check("bp_reload_valid", 32'(ov4), 32'd1);
    check("bp_reload_chan",  32'(oc4), 32'((held_c + 2'd1) % 4));

    // Channels 0 and 3 valid after channel 3 was last granted: strict alternation.
    md[0] = 1'b0; sel[0] = 3; vld[0] = 4'b1000;
    step();
    md[0] = 1'b1; vld[0] = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      check("alt_chan", 32'(oc4), (i % 2 == 0) ? 32'd0 : 32'd3);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        vld[d]  = 4'($urandom);
        md[d]   = ($urandom_range(0, 3) != 0);
        sel[d]  = $urandom_range(0, 3);
        ordy[d] = ($urandom_range(0, 2) != 0);
      end
      randomize_data();
      step();
    end

    // Asynchronous reset while a word is held.
    for (int d = 0; d < 2; d++) begin
      vld[d] = 4'hf; md[d] = 1'b1; ordy[d] = 1'b1;
    end
    step();
    check("pre_rst_valid", 32'(ov4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid4", 32'(ov4), 32'd0);
    check("async_data4",  32'(od4), 32'd0);
    check("async_chan4",  32'(oc4), 32'd0);
    check("async_valid3", 32'(ov3), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_chan4", 32'(oc4), 32'd0);
    check("post_rst_chan3", 32'(oc3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
